seg_scan_driver: RTL
====================

# seg_scan_driver

Time-multiplexed eight-digit seven-segment driver that consumes `code_t` character codes and drives the board's digit-select and segment lines. Display-side producers (menu, input, calculator result and error screens) encode screen content as `code_t` glyphs. This block is the decoding end: it double-buffers a frame, swaps it in only at frame boundaries, scans the digits, blanks between digits to avoid ghosting, and optionally blinks selected digits.

## Interface
Parameters:
- `CLK_FREQ`, default `SYS_CLK_FREQ` (100_000_000): input clock frequency in Hz.
- `SCAN_HZ`, default 1000: per-digit dwell rate in Hz. `DIV = CLK_FREQ/SCAN_HZ` cycles per digit; `DIV` must be ≥ `GUARD`+2.
- `GUARD`, default 4: blanking cycles at the start of each digit slot.
- `BLINK_DIV`, default 25_000_000: cycles per blink half-period.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous active-high reset.
- `upd_valid` in 1: a new frame is offered on the frame inputs.
- `upd_ready` out 1: the pending buffer is empty and can accept a frame.
- `digits` in `code_t [7:0]`: frame glyphs. Index 7 is the leftmost digit.
- `dp_in` in 8: decimal-point enables, one per digit.
- `blink_in` in 8: blink mask, one bit per digit.
- `an` out 8: digit select, active-high, one-hot or zero.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-high.
- `dp` out 1: decimal point, active-high.

## Operation
- Handshake: a frame (`digits`, `dp_in`, `blink_in`) is captured into the pending buffer when `upd_valid && upd_ready`. `upd_ready` then falls the next cycle.
- Swap: when the scan index wraps from 7 to 0 and the pending buffer is full, the pending buffer is copied to the active buffer and `upd_ready` rises the following cycle. Frames never tear mid-scan.
- If the pending buffer is full, a further `upd_valid` is ignored. The producer holds the frame until it sees `upd_ready`.
- If a capture and a swap happen in the same cycle, the swap uses the old pending content. The new capture is blocked because `upd_ready` was already 0 in that cycle.
- Scan: the divider counts 0..DIV-1. At DIV-1 it wraps, and the digit index advances 7→6→…→0→7 (wrap-around).
- Slot output: for divider values below `GUARD`, `an`, `seg` and `dp` are all 0. Otherwise, `an` is one-hot at the current index, `seg` is the glyph of the active code, and `dp` is the active dp bit.
- Glyph table (hex of seg[6:0]): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71, t(16)=78, J(17)=1E, r(18)=50, H/“-”(19)=40.
- `CHAR_BLK` (31) and the undefined codes 20..30 decode to 00.
- A blanked digit keeps `an` asserted with `seg`=0 and `dp`=0.
- Reset: divider 0, index 7, blink phase 0, active buffer all `CHAR_BLK` with dp/blink 0, pending buffer empty.
- Output reset values: `an`=0, `seg`=0, `dp`=0, `upd_ready`=1.
- Reset asserted mid-frame discards both buffers.

## Timing
- All outputs are registered. `an`, `seg` and `dp` reflect divider/index state with one cycle of latency.
- Capture to visible: at most 8·DIV+2 cycles. At minimum the new frame appears on the first digit-7 slot after the swap.
- `upd_ready` returns to 1 exactly one cycle after the swap.
- The blink counter runs continuously from reset. Its phase toggles every `BLINK_DIV` cycles.

## Configuration
- Macro: `SEG_BLINK_EN`.
- When defined, a digit whose active blink bit is 1 is blanked (`seg`=0, `dp`=0, `an` still asserted) while the blink phase is 1.
- When undefined, the blink counter and blink buffers are not built, and `blink_in` is accepted but ignored.

## Structure
- Shared package: add `SCAN_HZ_DEFAULT` and `BLINK_DIV_DEFAULT`, and a `seg_glyph_t` (logic [6:0]) typedef.
- The `code_t` and `CHAR_*` constants are already shared and must be used for the table.
- Sub-module: `seg_glyph_decode`, a pure combinational `code_t` → `seg_glyph_t` decoder, reused by any future display path.
- The top level holds the divider, index, buffers, handshake and blink logic.

## Test plan
Bench parameters: `CLK_FREQ`=1000, `SCAN_HZ`=100 (DIV=10), `GUARD`=2, `BLINK_DIV`=50.
- Reset, then run 100 cycles with no frame. Required: `an` cycles through the one-hot values 0x80..0x01, `seg` is always 00, and `upd_ready`=1.
- Offer digits = {E,r,r,BLK,BLK,BLK,H,1}, dp_in=0x02. Required: one-cycle handshake and `upd_ready`=0 until the swap. After the swap, the digit-7 slot shows seg=79, digit 1 shows seg=40 with dp=1, digit 0 shows seg=06, and each slot's first 2 cycles are blank.
- With a frame pending, present a second frame. Required: it is not accepted until `upd_ready` rises one cycle after the 0→7 wrap, and it is displayed on the following frame.
- Decode every code 0..31 in turn. Required: the glyph table matches exactly, and codes 20..31 give 00.
- With `SEG_BLINK_EN` defined, set blink_in=0x01 and digits[0]=8. Required: digit 0 alternates seg=7F and 00 every 50 cycles while `an`[0] still pulses. With the macro undefined, it is steady 7F.
- Assert `rst` mid-frame with a frame pending. Required: the next cycle gives `an`=0, `seg`=0, `upd_ready`=1, and the display is blank.

Source files
------------

// File: rtl/seg_scan_driver_pkg.sv
// Shared display definitions: character codes, glyph type and scan defaults.
package seg_scan_driver_pkg;

  localparam int SYS_CLK_FREQ      = 100_000_000;
  localparam int SCAN_HZ_DEFAULT   = 1000;
  localparam int BLINK_DIV_DEFAULT = 25_000_000;

  typedef logic [4:0] code_t;
  typedef logic [6:0] seg_glyph_t;

  localparam code_t CHAR_0    = 5'd0;
  localparam code_t CHAR_1    = 5'd1;
  localparam code_t CHAR_2    = 5'd2;
  localparam code_t CHAR_3    = 5'd3;
  localparam code_t CHAR_4    = 5'd4;
  localparam code_t CHAR_5    = 5'd5;
  localparam code_t CHAR_6    = 5'd6;
  localparam code_t CHAR_7    = 5'd7;
  localparam code_t CHAR_8    = 5'd8;
  localparam code_t CHAR_9    = 5'd9;
  localparam code_t CHAR_A    = 5'd10;
  localparam code_t CHAR_B    = 5'd11;
  localparam code_t CHAR_C    = 5'd12;
  localparam code_t CHAR_D    = 5'd13;
  localparam code_t CHAR_E    = 5'd14;
  localparam code_t CHAR_F    = 5'd15;
  localparam code_t CHAR_T    = 5'd16;
  localparam code_t CHAR_J    = 5'd17;
  localparam code_t CHAR_R    = 5'd18;
  localparam code_t CHAR_H    = 5'd19;  // drawn as a dash
  localparam code_t CHAR_BLK  = 5'd31;

endpackage

// File: rtl/seg_scan_driver_glyph_decode.sv
// seg_glyph_decode: combinational code_t to {g,f,e,d,c,b,a} segment pattern.
module seg_glyph_decode
  import seg_scan_driver_pkg::*;
(
  input  code_t      code,
  output seg_glyph_t glyph
);

  always_comb begin
    glyph = 7'h00;
    case (code)
      CHAR_0:  glyph = 7'h3F;
      CHAR_1:  glyph = 7'h06;
      CHAR_2:  glyph = 7'h5B;
      CHAR_3:  glyph = 7'h4F;
      CHAR_4:  glyph = 7'h66;
      CHAR_5:  glyph = 7'h6D;
      CHAR_6:  glyph = 7'h7D;
      CHAR_7:  glyph = 7'h07;
      CHAR_8:  glyph = 7'h7F;
      CHAR_9:  glyph = 7'h6F;
      CHAR_A:  glyph = 7'h77;
      CHAR_B:  glyph = 7'h7C;
      CHAR_C:  glyph = 7'h39;
      CHAR_D:  glyph = 7'h5E;
      CHAR_E:  glyph = 7'h79;
      CHAR_F:  glyph = 7'h71;
      CHAR_T:  glyph = 7'h78;
      CHAR_J:  glyph = 7'h1E;
      CHAR_R:  glyph = 7'h50;
      CHAR_H:  glyph = 7'h40;
      default: glyph = 7'h00;  // CHAR_BLK and unassigned codes
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed seven-segment driver with double-buffered frames.
// Optional per-digit blinking is built when SEG_BLINK_EN is defined.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int CLK_FREQ  = SYS_CLK_FREQ,
  parameter int SCAN_HZ   = SCAN_HZ_DEFAULT,
  parameter int GUARD     = 4,
  parameter int BLINK_DIV = BLINK_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  code_t [7:0] digits,
  input  logic  [7:0] dp_in,
  input  logic  [7:0] blink_in,
  output logic  [7:0] an,
  output logic  [6:0] seg,
  output logic        dp
);

  localparam int DIV   = CLK_FREQ / SCAN_HZ;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] GUARD_END = DIV_W'(GUARD);

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       scan_idx;
  code_t [7:0]      act_code;
  code_t [7:0]      pend_code;
  logic  [7:0]      act_dp;
  logic  [7:0]      pend_dp;

  logic       div_wrap;
  logic       frame_end;
  logic       swap;
  logic       capture;
  logic       slot_blank;
  logic       digit_off;
  code_t      cur_code;
  seg_glyph_t cur_glyph;

  assign div_wrap  = (div_cnt == DIV_LAST);
  assign frame_end = div_wrap && (scan_idx == 3'd0);
  // upd_ready low means the pending buffer holds a frame waiting for a swap
  assign swap      = frame_end && !upd_ready;
  assign capture   = upd_valid && upd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      scan_idx <= 3'd7;
    end else if (div_wrap) begin
      div_cnt  <= '0;
      scan_idx <= scan_idx - 3'd1;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      upd_ready <= 1'b1;
      act_code  <= {8{CHAR_BLK}};
      act_dp    <= '0;
      pend_code <= {8{CHAR_BLK}};
      pend_dp   <= '0;
    end else if (swap) begin
      act_code  <= pend_code;
      act_dp    <= pend_dp;
      upd_ready <= 1'b1;
    end else if (capture) begin
      pend_code <= digits;
      pend_dp   <= dp_in;
      upd_ready <= 1'b0;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLK_W-1:0] BLINK_LOAD = BLK_W'(BLINK_DIV - 1);

  logic [BLK_W-1:0] blink_cnt;
  logic             blink_phase;
  logic [7:0]       act_blink;
  logic [7:0]       pend_blink;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= BLINK_LOAD;
      blink_phase <= 1'b0;
    end else if (blink_cnt == '0) begin
      blink_cnt   <= BLINK_LOAD;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt - 1'b1;
    end
  end

  // blink mask follows the same capture/swap path as the glyphs
  always_ff @(posedge clk) begin
    if (rst) begin
      act_blink  <= '0;
      pend_blink <= '0;
    end else if (swap) begin
      act_blink  <= pend_blink;
    end else if (capture) begin
      pend_blink <= blink_in;
    end
  end

  assign digit_off = act_blink[scan_idx] && blink_phase;
`else
  logic blink_unused;
  assign blink_unused = ^blink_in;
  assign digit_off    = 1'b0;
`endif

  assign cur_code   = act_code[scan_idx];
  assign slot_blank = (div_cnt < GUARD_END);

  seg_glyph_decode u_glyph (
    .code  (cur_code),
    .glyph (cur_glyph)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= '0;
      seg <= '0;
      dp  <= 1'b0;
    end else if (slot_blank) begin
      an  <= '0;
      seg <= '0;
      dp  <= 1'b0;
    end else begin
      an  <= 8'd1 << scan_idx;
      seg <= digit_off ? 7'h00 : cur_glyph;
      dp  <= digit_off ? 1'b0 : act_dp[scan_idx];
    end
  end

endmodule
